ssd_entry_scan: RTL and testbench
=================================

Name: ssd_entry_scan

Overview:
Parametrised N-digit keypad-entry buffer and multiplexed seven-segment scanner. It sits between the keypad decoder/pulse detectors and the SSD pins. It accepts single-cycle hex key strobes and stores them in a digit buffer, using either single-digit or append entry mode. It time-multiplexes the buffer onto one shared segment bus with a one-hot digit select, scanned either automatically at a set refresh rate or manually by a step strobe.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
SCAN_HZ, 1000, per-digit dwell rate; localparam SCAN_DIV = CLK_FREQ/SCAN_HZ (must be >= 2)
NUM_DIGITS, 2, number of display digits (2..8)
FULL_POLICY, 0, append mode when the buffer is full: 0 = restart (clear, then store the key as the first digit); 1 = shift, discarding the oldest digit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle strobe: key_code is valid
key_code  in  4  hex key value 0x0..0xF
clear  in  1  one-cycle strobe: empty the buffer
mode  in  1  0 = single-digit entry, 1 = append entry
auto_scan  in  1  1 = free-running scan, 0 = manual scan
step  in  1  one-cycle strobe: advance the scan index (manual only)
seg  out  7  {g,f,e,d,c,b,a}, 1 = segment lit
dig_sel  out  NUM_DIGITS  one-hot active digit
entry_val  out  4*NUM_DIGITS  buffer contents; [3:0] = digit 0 = most recent
entry_cnt  out  $clog2(NUM_DIGITS+1)  number of valid digits
entry_full  out  1  entry_cnt == NUM_DIGITS

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). All state updates on posedge clk only.
- Reset values:
  - seg = 0
  - dig_sel = 1 (digit 0)
  - entry_val = 0, entry_cnt = 0, entry_full = 0
  - scan counter and scan index = 0
  - stored mode = 0
- Entry priority per cycle: rst > clear > mode change > key_valid.
  - clear, or a change of mode from its registered value, empties the buffer (val = 0, cnt = 0) on that edge.
  - A key_valid in the same cycle is dropped.
- Mode 0, key_valid: digit 0 <= key_code, all other digits <= 0, cnt <= 1.
- Mode 1, key_valid, cnt < N: shift up one digit (digit i <= digit i-1), digit 0 <= key_code, cnt + 1.
- Mode 1, key_valid, cnt == N:
  - FULL_POLICY 0: val <= {0..., key_code}, cnt <= 1.
  - FULL_POLICY 1: shift up, oldest digit lost, cnt stays N.
- Entry outputs are registered: visible 1 cycle after the strobe.
- Auto scan (auto_scan = 1):
  - Counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and the index increments.
  - Index wraps NUM_DIGITS-1 -> 0.
  - step is ignored.
- Manual scan (auto_scan = 0):
  - Counter is held at 0.
  - Each step increments the index with the same wrap.
- Switching auto_scan resets the counter to 0. The index is kept.
- Output stage: seg and dig_sel are registered from the same index, so they are always aligned.
  - dig_sel = one-hot(index), registered 1 cycle after the index changes.
  - seg = hex_to_seg(digit[index]) if index < entry_cnt, else 0 (blank unused digits). Registered 1 cycle after the index or buffer changes.
  - In mode 0, only digit 0 ever lights.
- Never drive dig_sel all-zero or multi-hot after reset.

Decomposition:
- Package ssd_pkg:
  - 7-bit segment constants for 0x0..0xF and SEG_BLANK.
  - Function/typedef for the digit nibble (digit_t = logic [3:0]).
- Sub-module hex_to_seg: combinational 4-bit -> 7-bit decoder using the package table. Shared with the existing display control path.
- The rest (entry buffer, scan counter, output registers) lives in ssd_entry_scan.

Test Plan:
- Common setup for all scenarios: CLK_FREQ = 1000, SCAN_HZ = 250 (SCAN_DIV = 4), NUM_DIGITS = 4.
- Reset, then auto_scan = 1 -> dig_sel steps 0001, 0010, 0100, 1000, 0001 every 4 clks; seg = 0 throughout (empty buffer).
- mode = 1, keys 1, 2, 3 -> entry_val = 0x0123, cnt = 3; while dig_sel = 0001 seg = 7'b1001111 ('3'); at 1000 seg = 0.
- FULL_POLICY 0, mode = 1, keys 1, 2, 3, 4, 5:
  - After key 4: entry_full = 1, val = 0x1234.
  - After key 5: val = 0x0005, cnt = 1, full = 0.
- FULL_POLICY 1, same keys -> val = 0x2345, cnt = 4, entry_full stays 1.
- mode = 0, keys 7 then 9 -> val = 0x0009, cnt = 1; toggling mode to 1 -> val = 0, cnt = 0 next clk.
- clear and key_valid (key A) in the same cycle -> val = 0, cnt = 0.
- Manual scan: auto_scan = 0 -> dig_sel frozen; 5 step pulses -> dig_sel = 0010.
- rst asserted mid-scan with val = 0x1234 -> next clk all outputs at reset values.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and seven-segment constants for the SSD display path.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 1 lights the segment.
package ssd_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder.
module hex_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_entry_scan.sv
// Keypad entry buffer plus multiplexed seven-segment scanner.
// Digit 0 (entry_val[3:0]) always holds the most recent key.
module ssd_entry_scan
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int NUM_DIGITS  = 2,
    parameter int FULL_POLICY = 0
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    input  logic                              clear,
    input  logic                              mode,
    input  logic                              auto_scan,
    input  logic                              step,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             dig_sel,
    output logic [4*NUM_DIGITS-1:0]           entry_val,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_cnt,
    output logic                              entry_full
);

    localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W    = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int SDIV_W   = $clog2(SCAN_DIV);
    localparam int VAL_W    = 4 * NUM_DIGITS;

    logic [VAL_W-1:0]      val_q, val_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [SDIV_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    digit_t                cur_digit;
    seg_t                  dec_seg;

    assign cur_digit = val_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Entry buffer: clear or a mode change empties it and drops any key that cycle.
    always_comb begin
        val_d  = val_q;
        cnt_d  = cnt_q;
        mode_d = mode;
        if (clear || (mode != mode_q)) begin
            val_d = '0;
            cnt_d = '0;
        end else if (key_valid) begin
            if (!mode) begin
                val_d = {{(VAL_W-4){1'b0}}, key_code};
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_W'(NUM_DIGITS)) begin
                val_d = {val_q[VAL_W-5:0], key_code};
                cnt_d = cnt_q + CNT_W'(1);
            end else if (FULL_POLICY == 0) begin
                val_d = {{(VAL_W-4){1'b0}}, key_code};
                cnt_d = CNT_W'(1);
            end else begin
                val_d = {val_q[VAL_W-5:0], key_code};
                cnt_d = cnt_q;
            end
        end
    end

    // Scan index: dwell counter in auto mode, step strobe in manual mode (counter parked at 0).
    always_comb begin
        idx_next   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        scan_cnt_d = '0;
        idx_d      = idx_q;
        if (auto_scan) begin
            if (scan_cnt_q == SDIV_W'(SCAN_DIV - 1)) begin
                idx_d = idx_next;
            end else begin
                scan_cnt_d = scan_cnt_q + SDIV_W'(1);
            end
        end else if (step) begin
            idx_d = idx_next;
        end
    end

    // Output stage: select and segments come from the same index so they stay aligned.
    always_comb begin
        dig_sel_d        = '0;
        dig_sel_d[idx_q] = 1'b1;
        seg_d            = (CNT_W'(idx_q) < cnt_q) ? dec_seg : SEG_BLANK;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            dig_sel_q  <= NUM_DIGITS'(1);
        end else begin
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign entry_val  = val_q;
    assign entry_cnt  = cnt_q;
    assign entry_full = (cnt_q == CNT_W'(NUM_DIGITS));

endmodule

// File: tb/tb_ssd_entry_scan.sv
// Bench for ssd_entry_scan: two instances (restart and shift full-policy) share stimulus
// and are compared every cycle against a behavioural model of the buffer and scanner.
module tb_ssd_entry_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic clear = 1'b0;
    logic mode = 1'b0;
    logic auto_scan = 1'b0;
    logic step = 1'b0;

    logic [6:0]  seg0, seg1;
    logic [3:0]  sel0, sel1;
    logic [15:0] val0, val1;
    logic [2:0]  cnt0, cnt1;
    logic        full0, full1;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: digits per policy (index 0 = newest), counts, scan position
    int m_dg[2][N];
    int m_cnt[2];
    int m_mode;
    int m_phase;
    int m_idx;
    int e_seg[2];
    int e_sel;

    always #5 clk = ~clk;

    ssd_entry_scan #(.CLK_FREQ(1000), .SCAN_HZ(250), .NUM_DIGITS(N), .FULL_POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .clear(clear),
        .mode(mode), .auto_scan(auto_scan), .step(step), .seg(seg0), .dig_sel(sel0),
        .entry_val(val0), .entry_cnt(cnt0), .entry_full(full0));

    ssd_entry_scan #(.CLK_FREQ(1000), .SCAN_HZ(250), .NUM_DIGITS(N), .FULL_POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .clear(clear),
        .mode(mode), .auto_scan(auto_scan), .step(step), .seg(seg1), .dig_sel(sel1),
        .entry_val(val1), .entry_cnt(cnt1), .entry_full(full1));

    function automatic int segof(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input int p);
        logic [15:0] v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_dg[p][i]);
        return v;
    endfunction

    // One clock: advance the model from current inputs, then compare all outputs.
    task automatic tick();
        int nseg[2];
        int nsel;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < N; i++) m_dg[p][i] = 0;
                m_cnt[p] = 0;
                nseg[p]  = 0;
            end
            nsel = 1; m_mode = 0; m_phase = 0; m_idx = 0;
        end else begin
            nsel = 1 << m_idx;
            for (int p = 0; p < 2; p++)
                nseg[p] = (m_idx < m_cnt[p]) ? segof(m_dg[p][m_idx]) : 0;
            for (int p = 0; p < 2; p++) begin
                if (clear || (int'(mode) != m_mode)) begin
                    for (int i = 0; i < N; i++) m_dg[p][i] = 0;
                    m_cnt[p] = 0;
                end else if (key_valid) begin
                    if (!mode || (m_cnt[p] == N && p == 0)) begin
                        for (int i = 0; i < N; i++) m_dg[p][i] = 0;
                        m_dg[p][0] = key_code;
                        m_cnt[p] = 1;
                    end else begin
                        for (int i = N - 1; i > 0; i--) m_dg[p][i] = m_dg[p][i-1];
                        m_dg[p][0] = key_code;
                        if (m_cnt[p] < N) m_cnt[p]++;
                    end
                end
            end
            m_mode = mode;
            if (auto_scan) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_idx = (m_idx + 1) % N;
                end
            end else begin
                m_phase = 0;
                if (step) m_idx = (m_idx + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        e_seg = nseg;
        e_sel = nsel;
        chk("seg0", seg0, e_seg[0]);
        chk("seg1", seg1, e_seg[1]);
        chk("dig_sel0", sel0, e_sel);
        chk("dig_sel1", sel1, e_sel);
        chk("val0", val0, pack(0));
        chk("val1", val1, pack(1));
        chk("cnt0", cnt0, m_cnt[0]);
        chk("cnt1", cnt1, m_cnt[1]);
        chk("full0", full0, m_cnt[0] == N);
        chk("full1", full1, m_cnt[1] == N);
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_seg", seg0, 7'd0);
        chk("rst_sel", sel0, 4'b0001);
        chk("rst_val", val0, 16'h0000);

        // auto scan over an empty buffer
        rst = 1'b0;
        auto_scan = 1'b1;
        repeat (20) tick();

        // append three keys
        mode = 1'b1;
        tick();
        press(4'h1);
        press(4'h2);
        press(4'h3);
        chk("app3_val_lit", val0, 16'h0123);
        chk("app3_cnt_lit", cnt0, 3'd3);
        repeat (16) begin
            tick();
            if (sel0 == 4'b0001) chk("app3_seg_d0_lit", seg0, 7'b1001111);
            if (sel0 == 4'b1000) chk("app3_seg_d3_lit", seg0, 7'b0000000);
        end

        // fill and overflow under both policies
        press(4'h4);
        chk("full_lit0", full0, 1'b1);
        chk("full_val_lit", val0, 16'h1234);
        press(4'h5);
        chk("restart_val_lit", val0, 16'h0005);
        chk("restart_cnt_lit", cnt0, 3'd1);
        chk("restart_full_lit", full0, 1'b0);
        chk("shift_val_lit", val1, 16'h2345);
        chk("shift_cnt_lit", cnt1, 3'd4);
        chk("shift_full_lit", full1, 1'b1);

        // single-digit mode, then a mode toggle clears
        mode = 1'b0;
        tick();
        press(4'h7);
        press(4'h9);
        chk("single_val_lit", val0, 16'h0009);
        chk("single_cnt_lit", cnt0, 3'd1);
        mode = 1'b1;
        tick();
        chk("toggle_val_lit", val0, 16'h0000);
        chk("toggle_cnt_lit", cnt0, 3'd0);

        // clear wins over a simultaneous key
        press(4'h1);
        press(4'h2);
        clear = 1'b1;
        press(4'hA);
        clear = 1'b0;
        chk("clr_key_val_lit", val0, 16'h0000);
        chk("clr_key_cnt_lit", cnt0, 3'd0);

        // manual scan from a fresh reset
        rst = 1'b1;
        auto_scan = 1'b0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("manual_frozen_lit", sel0, 4'b0001);
        repeat (5) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        chk("manual_step5_lit", sel0, 4'b0010);

        // reset in the middle of an auto scan with a full buffer
        auto_scan = 1'b1;
        tick();
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        repeat (6) tick();
        chk("mid_val_lit", val0, 16'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_seg", seg0, 7'd0);
        chk("mid_rst_sel", sel0, 4'b0001);
        chk("mid_rst_val", val0, 16'h0000);
        chk("mid_rst_cnt", cnt0, 3'd0);
        chk("mid_rst_full", full0, 1'b0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clear     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0) auto_scan = ~auto_scan;
            step      = ($urandom_range(0, 3) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_code  = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
